// File: rtl/accum_window_drain.sv
// accum_window_drain: drain stage behind the DSP accumulator.
// Counts enabled accumulation cycles into fixed windows and captures the
// running sum at each window end or on flush. Pulses a clear back to the
// accumulator, then scales, optionally rounds and saturates the captured sum.
// Results queue in a 2-entry show-ahead FIFO behind a valid/ready handshake.
// Optional feature: define ACCUM_DRAIN_ROUND_EN to round half toward +inf
// before the shift. When it is undefined, the shift is a plain floor.
module accum_window_drain #(
   parameter int IN_W   = 38,
   parameter int OUT_W  = 20,
   parameter int SHIFT  = 8,
   parameter int WINDOW = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en_i,
   input  logic [IN_W-1:0]            p_i,
   input  logic                       flush_i,
   output logic                       clr_o,
   output logic [OUT_W-1:0]           data_o,
   output logic                       sat_o,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic                       ovf_o,
   output logic [$clog2(WINDOW)-1:0]  cnt_o
);

   localparam int CNT_W = $clog2(WINDOW);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

   // Saturation bounds, expressed at the widened IN_W+1 signed width.
   localparam logic signed [IN_W:0] MAX_V = {{(IN_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
   localparam logic signed [IN_W:0] MIN_V = {{(IN_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

`ifdef ACCUM_DRAIN_ROUND_EN
   localparam logic signed [IN_W:0] ROUND_V = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
`endif

   // Stage 1 state: window count, captured sum and the clear pulse.
   logic [CNT_W-1:0]  cnt_q;
   logic [IN_W-1:0]   cap_q;
   logic              cap_v_q;
   logic              clr_q;
   logic              capture_d;

   // Stage 2 combinational result.
   logic signed [IN_W:0] ext_d;
   logic signed [IN_W:0] shifted_d;
   logic [OUT_W-1:0]     res_d;
   logic                 sat_d;

   // FIFO state.
   logic [OUT_W-1:0] mem_data_q [2];
   logic             mem_sat_q  [2];
   logic             rd_ptr_q;
   logic             wr_ptr_q;
   logic [1:0]       count_q;
   logic             ovf_q;
   logic             push_d;
   logic             pop_d;
   logic             accept_d;

   // A flush and a terminal count on the same edge merge into one capture.
   always_comb begin
      capture_d = flush_i | (en_i & (cnt_q == CNT_LAST));
   end

   // Window counter, capture register and the one-cycle clear pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         cap_q   <= '0;
         cap_v_q <= 1'b0;
         clr_q   <= 1'b0;
      end else begin
         cap_v_q <= capture_d;
         clr_q   <= capture_d;
         if (capture_d) begin
            cap_q <= p_i;
            cnt_q <= '0;
         end else if (en_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   // Sign-extend, optionally round, shift and saturate the captured sum.
   always_comb begin
      ext_d = {cap_q[IN_W-1], cap_q};
`ifdef ACCUM_DRAIN_ROUND_EN
      ext_d = ext_d + ROUND_V;
`endif
      shifted_d = ext_d >>> SHIFT;
      res_d     = shifted_d[OUT_W-1:0];
      sat_d     = 1'b0;
      if (shifted_d > MAX_V) begin
         res_d = MAX_V[OUT_W-1:0];
         sat_d = 1'b1;
      end else if (shifted_d < MIN_V) begin
         res_d = MIN_V[OUT_W-1:0];
         sat_d = 1'b1;
      end
   end

   // A push into a full FIFO only lands if the head leaves on the same edge.
   always_comb begin
      push_d   = cap_v_q;
      pop_d    = (count_q != 2'd0) & ready_i;
      accept_d = push_d & ((count_q != 2'd2) | pop_d);
   end

   // FIFO storage, pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_data_q[0] <= '0;
         mem_data_q[1] <= '0;
         mem_sat_q[0]  <= 1'b0;
         mem_sat_q[1]  <= 1'b0;
         rd_ptr_q      <= 1'b0;
         wr_ptr_q      <= 1'b0;
         count_q       <= 2'd0;
         ovf_q         <= 1'b0;
      end else begin
         if (accept_d) begin
            mem_data_q[wr_ptr_q] <= res_d;
            mem_sat_q[wr_ptr_q]  <= sat_d;
            wr_ptr_q             <= ~wr_ptr_q;
         end
         if (pop_d) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({accept_d, pop_d})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
         if (push_d & ~accept_d) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // Output mapping: the head entry is shown ahead of the pop.
   always_comb begin
      clr_o   = clr_q;
      cnt_o   = cnt_q;
      data_o  = mem_data_q[rd_ptr_q];
      sat_o   = mem_sat_q[rd_ptr_q];
      valid_o = (count_q != 2'd0);
      ovf_o   = ovf_q;
   end

endmodule

// File: tb/tb_accum_window_drain.sv
// tb_accum_window_drain: self-checking bench for accum_window_drain.
// Runs directed scenarios with literal expectations, then random traffic,
// all compared every cycle against a queue-based behavioural model.
module tb_accum_window_drain;

   localparam int IN_W   = 38;
   localparam int OUT_W  = 20;
   localparam int SHIFT  = 8;
   localparam int WINDOW = 4;
   localparam int CNT_W  = $clog2(WINDOW);

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              en_i = 1'b0;
   logic [IN_W-1:0]   p_i = '0;
   logic              flush_i = 1'b0;
   logic              ready_i = 1'b1;
   logic              clr_o;
   logic [OUT_W-1:0]  data_o;
   logic              sat_o;
   logic              valid_o;
   logic              ovf_o;
   logic [CNT_W-1:0]  cnt_o;

   int checks = 0;
   int failures = 0;

   // Behavioural model state
   int     mCnt = 0;
   bit     mClr = 0;
   bit     mOvf = 0;
   bit     mPendV = 0;
   longint mPendP = 0;
   longint mQData[$];
   bit     mQSat[$];

   accum_window_drain #(
      .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .WINDOW(WINDOW)
   ) dut (
      .clk(clk), .reset(reset), .en_i(en_i), .p_i(p_i), .flush_i(flush_i),
      .clr_o(clr_o), .data_o(data_o), .sat_o(sat_o), .valid_o(valid_o),
      .ready_i(ready_i), .ovf_o(ovf_o), .cnt_o(cnt_o)
   );

   always #5 clk = ~clk;

   // Scaled value before saturation
   function automatic longint scaledRaw(input longint p);
`ifdef ACCUM_DRAIN_ROUND_EN
      return (p + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
`else
      return p >>> SHIFT;
`endif
   endfunction

   function automatic longint scaleData(input longint p);
      longint s, hi, lo;
      s  = scaledRaw(p);
      hi = (longint'(1) << (OUT_W - 1)) - 1;
      lo = -(longint'(1) << (OUT_W - 1));
      if (s > hi) return hi;
      if (s < lo) return lo;
      return s;
   endfunction

   function automatic bit scaleSat(input longint p);
      longint s;
      s = scaledRaw(p);
      return (s > (longint'(1) << (OUT_W - 1)) - 1) || (s < -(longint'(1) << (OUT_W - 1)));
   endfunction

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Model: window rules, one-edge capture delay, bounded queue with drops
   always @(posedge clk or posedge reset) begin
      bit popNow, fullNoPop, capNow;
      if (reset) begin
         mCnt = 0; mClr = 0; mOvf = 0; mPendV = 0; mPendP = 0;
         mQData.delete(); mQSat.delete();
      end else begin
         popNow    = (mQData.size() > 0) && ready_i;
         fullNoPop = (mQData.size() == 2) && !popNow;
         if (popNow) begin
            void'(mQData.pop_front());
            void'(mQSat.pop_front());
         end
         if (mPendV) begin
            if (fullNoPop) mOvf = 1;
            else begin
               mQData.push_back(scaleData(mPendP));
               mQSat.push_back(scaleSat(mPendP));
            end
         end
         capNow = flush_i || (en_i && mCnt == WINDOW - 1);
         mClr   = capNow;
         mPendV = capNow;
         if (capNow) mPendP = longint'($signed(p_i));
         if (capNow) mCnt = 0;
         else if (en_i) mCnt = mCnt + 1;
      end
   end

   // Per-cycle comparison of DUT outputs against the model
   always @(negedge clk) begin
      if (!reset) begin
         checkOutput("clr", longint'(clr_o), longint'(mClr));
         checkOutput("cnt", longint'(cnt_o), longint'(mCnt));
         checkOutput("valid", longint'(valid_o), longint'(mQData.size() > 0));
         checkOutput("ovf", longint'(ovf_o), longint'(mOvf));
         if (mQData.size() > 0) begin
            checkOutput("data", longint'($signed(data_o)), mQData[0]);
            checkOutput("sat", longint'(sat_o), longint'(mQSat[0]));
         end
      end
   end

   // Drive one cycle of inputs at the negedge, return at the next negedge
   task automatic applyStimulus(input bit en, input longint p, input bit flush, input bit ready);
      en_i    = en;
      p_i     = IN_W'(p);
      flush_i = flush;
      ready_i = ready;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Flush-capture a value and check the scaled head two edges later
   task automatic runCapture(input longint p, input longint expData, input bit expSat);
      applyStimulus(0, p, 1, 1);
      checkOutput("lit_cap_clr", longint'(clr_o), 1);
      applyStimulus(0, 0, 0, 1);
      checkOutput("lit_cap_valid", longint'(valid_o), 1);
      checkOutput("lit_cap_data", longint'($signed(data_o)), expData);
      checkOutput("lit_cap_sat", longint'(sat_o), longint'(expSat));
      applyStimulus(0, 0, 0, 1);
   endtask

   initial begin
      longint pv;
      logic [IN_W-1:0] raw;
      bit en, fl, rd;

      repeat (2) @(negedge clk);
      checkOutput("rst_cnt", longint'(cnt_o), 0);
      checkOutput("rst_valid", longint'(valid_o), 0);
      checkOutput("rst_data", longint'(data_o), 0);
      checkOutput("rst_clr", longint'(clr_o), 0);
      checkOutput("rst_ovf", longint'(ovf_o), 0);
      reset = 1'b0;

      $display("[TB] window and clear");
      applyStimulus(1, 0, 0, 1);
      applyStimulus(1, 0, 0, 1);
      applyStimulus(1, 0, 0, 1);
      checkOutput("lit_win_cnt3", longint'(cnt_o), 3);
      checkOutput("lit_win_noclr", longint'(clr_o), 0);
      applyStimulus(1, 'h500, 0, 1);
      checkOutput("lit_win_clr", longint'(clr_o), 1);
      checkOutput("lit_win_wrap", longint'(cnt_o), 0);
      checkOutput("lit_win_notyet", longint'(valid_o), 0);
      applyStimulus(0, 0, 0, 1);
      checkOutput("lit_win_clr_end", longint'(clr_o), 0);
      checkOutput("lit_win_valid", longint'(valid_o), 1);
      checkOutput("lit_win_data", longint'($signed(data_o)), 5);
      checkOutput("lit_win_sat", longint'(sat_o), 0);
      applyStimulus(0, 0, 0, 1);
      checkOutput("lit_win_popped", longint'(valid_o), 0);

      $display("[TB] rounding and saturation");
`ifdef ACCUM_DRAIN_ROUND_EN
      runCapture('h180, 2, 0);
      runCapture(-'h180, -1, 0);
`else
      runCapture('h180, 1, 0);
      runCapture(-'h180, -2, 0);
`endif
      runCapture(longint'(1) << 30, 524287, 1);
      runCapture(-(longint'(1) << 30), -524288, 1);
      runCapture(longint'(1) << 26, 262144, 0);

      $display("[TB] backpressure and overflow");
      applyStimulus(0, 'h100, 1, 0);
      applyStimulus(0, 'h200, 1, 0);
      applyStimulus(0, 'h300, 1, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("lit_bp_valid", longint'(valid_o), 1);
      checkOutput("lit_bp_head", longint'($signed(data_o)), 1);
      checkOutput("lit_bp_ovf", longint'(ovf_o), 1);
      applyStimulus(0, 0, 0, 1);
      checkOutput("lit_bp_head2", longint'($signed(data_o)), 2);
      applyStimulus(0, 0, 0, 1);
      checkOutput("lit_bp_empty", longint'(valid_o), 0);
      checkOutput("lit_bp_ovf_sticky", longint'(ovf_o), 1);

      $display("[TB] flush and simultaneity");
      applyStimulus(1, 0, 0, 1);
      checkOutput("lit_fl_cnt1", longint'(cnt_o), 1);
      applyStimulus(0, 'h700, 1, 1);
      checkOutput("lit_fl_cnt0", longint'(cnt_o), 0);
      checkOutput("lit_fl_clr", longint'(clr_o), 1);
      applyStimulus(0, 0, 0, 1);
      checkOutput("lit_fl_clr_once", longint'(clr_o), 0);
      checkOutput("lit_fl_data", longint'($signed(data_o)), 7);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 'h900, 1, 0);
      checkOutput("lit_tc_clr", longint'(clr_o), 1);
      applyStimulus(0, 0, 0, 0);
      checkOutput("lit_tc_clr_once", longint'(clr_o), 0);
      checkOutput("lit_tc_data", longint'($signed(data_o)), 9);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1);
      checkOutput("lit_tc_single", longint'(valid_o), 0);

      $display("[TB] reset mid-operation");
      applyStimulus(0, 'h100, 1, 0);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      checkOutput("lit_rm_cnt2", longint'(cnt_o), 2);
      checkOutput("lit_rm_pending", longint'(valid_o), 1);
      #2 reset = 1'b1;
      #1;
      checkOutput("lit_rm_valid", longint'(valid_o), 0);
      checkOutput("lit_rm_data", longint'(data_o), 0);
      checkOutput("lit_rm_cnt", longint'(cnt_o), 0);
      checkOutput("lit_rm_ovf", longint'(ovf_o), 0);
      checkOutput("lit_rm_clr", longint'(clr_o), 0);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(1, 0, 0, 1);
      applyStimulus(1, 0, 0, 1);
      applyStimulus(1, 0, 0, 1);
      checkOutput("lit_rm_noclr", longint'(clr_o), 0);
      applyStimulus(1, 'h400, 0, 1);
      checkOutput("lit_rm_clr4", longint'(clr_o), 1);
      applyStimulus(0, 0, 0, 1);
      checkOutput("lit_rm_data4", longint'($signed(data_o)), 4);

      $display("[TB] random traffic");
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            raw = IN_W'({$urandom(), $urandom()});
            pv  = longint'($signed(raw));
         end else begin
            pv = longint'($signed($urandom())) >>> $urandom_range(0, 8);
         end
         en = mClr ? 1'b0 : ($urandom_range(0, 3) != 0);
         fl = ($urandom_range(0, 15) == 0);
         if ((i % 500) < 120) rd = ($urandom_range(0, 7) == 0);
         else rd = ($urandom_range(0, 3) != 0);
         applyStimulus(en, pv, fl, rd);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
